// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit
//   Sequential unsigned divider feeding the HI/LO register pair of the ALU
//   datapath. A DIVU request accepted in IDLE runs one restoring step per
//   clock and leaves the quotient in LO and the remainder in HI. A zero
//   divisor skips the iteration and writes LO = all ones, HI = dividend.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low reset
//   dataA      in   WIDTH  dividend (sampled on the accept edge only)
//   dataB      in   WIDTH  divisor  (sampled on the accept edge only)
//   Signal     in   6      function code; DIVU_CODE requests a divide
//   HiOut      out  WIDTH  remainder of the last completed divide
//   LoOut      out  WIDTH  quotient of the last completed divide
//   busy       out  1      high exactly while the iteration is running
//   done       out  1      one-cycle pulse, HiOut/LoOut were just written
//   state_dbg  out  2      current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a request is a single-cycle look at Signal while the unit is
// idle (busy==0 and done==0). Requests seen in RUN or DONE are dropped, not
// queued; the requester reissues after done or once busy is low.
module divu_hilo_unit #(
   parameter int         WIDTH     = 32,
   parameter logic [5:0] DIVU_CODE = 6'b011011
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH:0]   rem;       // partial remainder, one guard bit
   logic [WIDTH-1:0] quo;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             take;

   // One restoring step: bring in the next dividend bit, subtract the
   // divisor when it fits and record a 1 in the quotient.
   always_comb begin
      rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
      take      = (rem_shift >= {1'b0, dvs});
      rem_next  = take ? (rem_shift - {1'b0, dvs}) : rem_shift;
      quo_next  = {quo[WIDTH-2:0], take};
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         HiOut <= '0;
         LoOut <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Signal == DIVU_CODE) begin
                  rem <= '0;
                  quo <= dataA;
                  dvs <= dataB;
                  cnt <= '0;
                  if (dataB != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     LoOut <= '1;
                     HiOut <= dataA;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  LoOut <= quo_next;
                  HiOut <= rem_next[WIDTH-1:0];
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// tb_divu_hilo_unit
//   Directed and random DIVU sequences against a reference built from plain
//   integer division, with latency, busy length, HI/LO hold and reset cases.
module tb_divu_hilo_unit;

   localparam int         W      = 32;
   localparam logic [5:0] DIVU   = 6'b011011;
   localparam logic [5:0] ADD    = 6'b100000;
   localparam logic [5:0] MFHI   = 6'b010000;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] dataA, dataB;
   logic [5:0]   Signal;
   logic [W-1:0] HiOut, LoOut;
   logic         busy, done;
   logic [1:0]   state_dbg;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];      // reference results: quotient, then remainder
   logic [W-1:0] cur_hi, cur_lo;

   divu_hilo_unit #(.WIDTH(W), .DIVU_CODE(DIVU)) dut (
      .clk       (clk),
      .reset     (reset),
      .dataA     (dataA),
      .dataB     (dataB),
      .Signal    (Signal),
      .HiOut     (HiOut),
      .LoOut     (LoOut),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model: unsigned divide with the divide-by-zero convention
   task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) begin
         exp_q.push_back('1);
         exp_q.push_back(a);
      end else begin
         exp_q.push_back(a / b);
         exp_q.push_back(a % b);
      end
   endtask

   // Issue one DIVU and follow it to completion. Inputs change on negedges;
   // outputs are sampled on negedges. k counts edges after the accept edge.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, input string tag);
      int       busy_cnt, done_k, exp_k;
      bit       hold_ok;
      logic [W-1:0] eq, er;
      model_push(a, b);
      exp_k    = (b == '0) ? 0 : W;
      busy_cnt = 0;
      done_k   = -1;
      hold_ok  = 1'b1;
      @(negedge clk);
      dataA = a; dataB = b; Signal = DIVU;
      @(posedge clk);
      #1;
      Signal = ADD;
      dataA  = $urandom;
      dataB  = $urandom;
      for (int k = 0; k <= W + 4 && done_k < 0; k++) begin
         @(negedge clk);
         if (done) done_k = k;
         else begin
            if (busy) busy_cnt++;
            if (HiOut !== cur_hi || LoOut !== cur_lo) hold_ok = 1'b0;
         end
         if (disturb && k == 5) begin
            Signal = DIVU; dataA = 50; dataB = 5;
         end else if (disturb && k == 8) begin
            Signal = MFHI;
         end else begin
            Signal = ADD;
         end
      end
      Signal = ADD;
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      check({tag, " done_latency"}, W'(done_k), W'(exp_k));
      check({tag, " busy_cycles"}, W'(busy_cnt), W'(exp_k));
      check({tag, " hilo_hold"}, W'(hold_ok), W'(1));
      check({tag, " lo"}, LoOut, eq);
      check({tag, " hi"}, HiOut, er);
      @(negedge clk);
      check({tag, " done_one_cycle"}, W'(done), W'(0));
      cur_lo = eq;
      cur_hi = er;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           done_seen;
      reset  = 1'b0;
      dataA  = '0;
      dataB  = '0;
      Signal = ADD;
      cur_hi = '0;
      cur_lo = '0;

      // 1: reset state
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst hi", HiOut, '0);
      check("rst lo", LoOut, '0);
      check("rst busy", W'(busy), W'(0));
      check("rst done", W'(done), W'(0));

      // 2-4: directed divides
      run_div(100, 7, 1'b0, "d100_7");
      run_div(32'hFFFF_FFFF, 1, 1'b0, "dmax_1");
      run_div(5, 9, 1'b0, "d5_9");
      run_div(123, 0, 1'b0, "d123_0");
      run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "dmax_max");

      // 5: DIVU and MFHI while running are ignored
      run_div(100, 7, 1'b1, "dist100_7");

      // 6: reset in the middle of a run discards it
      @(negedge clk);
      dataA = 1000; dataB = 3; Signal = DIVU;
      @(posedge clk);
      #1 Signal = ADD;
      repeat (10) @(negedge clk);
      check("mid busy", W'(busy), W'(1));
      reset = 1'b0;
      @(negedge clk);
      check("midrst busy", W'(busy), W'(0));
      check("midrst done", W'(done), W'(0));
      check("midrst hi", HiOut, '0);
      check("midrst lo", LoOut, '0);
      reset = 1'b1;
      cur_hi = '0;
      cur_lo = '0;
      done_seen = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("midrst no_done", W'(done_seen), W'(0));
      run_div(9, 3, 1'b0, "d9_3");

      // reset and DIVU on the same edge: reset wins
      @(negedge clk);
      reset = 1'b0; dataA = 77; dataB = 4; Signal = DIVU;
      @(negedge clk);
      reset = 1'b1; Signal = ADD;
      @(negedge clk);
      check("rstwin busy", W'(busy), W'(0));
      check("rstwin done", W'(done), W'(0));
      check("rstwin lo", LoOut, '0);
      cur_hi = '0;
      cur_lo = '0;

      // random divides
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = W'($urandom_range(1, 15));
            1: rb = $urandom;
            2: rb = ra >> $urandom_range(0, 8);
            default: rb = W'($urandom_range(0, 2));
         endcase
         run_div(ra, rb, 1'b0, $sformatf("rnd%0d", i));
      end

      // back-to-back without idle gap beyond the mandatory one
      run_div(1, 1, 1'b0, "b2b_a");
      run_div(0, 5, 1'b0, "b2b_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
